fir_xifu_ctrl: RTL and testbench
================================

FIR_XIFU_CTRL -- requirements
Module: fir_xifu_ctrl

Interface
REQ-001 Parameter: ID_W, default 4, width of the X-interface instruction id; NID = 2**ID_W scoreboard entries.
REQ-002 Parameter: MAX_OUT, default 4, maximum simultaneously issued-not-cleared instructions (1..NID).
REQ-003 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 Port: issue_valid_i  input  1  core offers an instruction on the issue channel.
REQ-006 Port: issue_id_i  input  ID_W  id of the offered instruction.
REQ-007 Port: issue_decoded_i  input  1  decoder recognises the offered instruction as a FIR op.
REQ-008 Port: pipe_ready_i  input  1  first pipeline stage can take a new instruction.
REQ-009 Port: issue_ready_o  output  1  issue handshake ready.
REQ-010 Port: issue_accept_o  output  1  instruction accepted by the coprocessor.
REQ-011 Port: commit_valid_i  input  1  commit channel valid.
REQ-012 Port: commit_id_i  input  ID_W  id being committed or killed.
REQ-013 Port: commit_kill_i  input  1  1 = kill, 0 = commit.
REQ-014 Port: clear_i  input  NID  one-hot-or-zero retire request from writeback.
REQ-015 Port: issue_o / commit_o / kill_o  output  NID each  scoreboard vectors towards writeback.
REQ-016 Port: outstanding_o  output  $clog2(MAX_OUT+1)  number of set issue_o bits.
REQ-017 Port: busy_o  output  1  high when outstanding_o != 0.
REQ-018 Port: err_o  output  1  sticky protocol-error flag.

Function
REQ-019 issue_ready_o SHALL be combinational: pipe_ready_i & ~issue_o[issue_id_i] & (outstanding_o < MAX_OUT).
REQ-020 issue_accept_o SHALL equal issue_decoded_i whenever issue_valid_i is high, else 0.
REQ-021 An issue handshake (issue_valid_i & issue_ready_o & issue_decoded_i) SHALL set issue_o[id] and clear commit_o[id], kill_o[id] on the next edge; undecoded handshakes change no state.
REQ-022 commit_valid_i with commit_kill_i=0 SHALL set commit_o[commit_id_i]; with commit_kill_i=1 SHALL set kill_o[commit_id_i]; both next edge.
REQ-023 A commit/kill for an id whose issue_o bit is 0 and is not being issued in the same cycle SHALL be ignored and SHALL set err_o.
REQ-024 clear_i[k]=1 SHALL clear issue_o[k], commit_o[k], kill_o[k] next edge; clear_i on an entry with issue_o[k]=0 SHALL be a no-op.
REQ-025 More than one bit set in clear_i SHALL set err_o; all requested bits are still cleared.
REQ-026 Same-cycle issue and commit/kill of the same id: issue_o and commit_o (or kill_o) SHALL both be 1 after the edge.
REQ-027 Same-cycle clear and issue of the same id cannot occur (REQ-019 blocks it); if forced, issue SHALL win.
REQ-028 Same-cycle clear and commit/kill of the same id: clear SHALL win and err_o SHALL not be set.
REQ-029 outstanding_o SHALL be a registered counter: +1 on accepted issue, -1 on effective clear, unchanged when both; SHALL never exceed MAX_OUT nor underflow.
REQ-030 Latency: every scoreboard output SHALL reflect an event exactly one cycle after it; no combinational path from commit or clear inputs to outputs.
REQ-031 err_o SHALL remain 1 until reset.

Reset
REQ-032 While rst_ni=0: issue_o, commit_o, kill_o = 0, outstanding_o = 0, busy_o = 0, err_o = 0, asynchronously, including mid-operation; in-flight handshakes in that cycle are discarded.
REQ-033 First edge after rst_ni rises SHALL process inputs normally.

Verification
REQ-034 Issue id 3 (decoded, pipe_ready_i=1) -> next cycle issue_o=0x0008, outstanding_o=1, busy_o=1; reissue of id 3 sees issue_ready_o=0.
REQ-035 Commit id 3, then clear_i=0x0008 -> commit_o=0x0008 one cycle after commit, then all vectors 0, outstanding_o=0.
REQ-036 MAX_OUT=4: issue ids 0..3 back-to-back -> issue_ready_o=0 for id 4; clear id 1 -> id 4 accepted next cycle.
REQ-037 Kill id 2 same cycle as its issue -> issue_o[2]=1, kill_o[2]=1, commit_o[2]=0, err_o=0.
REQ-038 Commit id 7 never issued -> commit_o unchanged, err_o=1 and stays 1.
REQ-039 rst_ni low with 3 outstanding -> all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fir_xifu_ctrl.sv
// Issue/commit/kill scoreboard for the FIR coprocessor on the X-interface.
// Tracks one entry per instruction id, bounds in-flight ops and flags protocol errors.
module fir_xifu_ctrl #(
    parameter  int ID_W    = 4,
    parameter  int MAX_OUT = 4,
    localparam int NID     = 2**ID_W,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_valid_i,
    input  logic [ID_W-1:0]  issue_id_i,
    input  logic             issue_decoded_i,
    input  logic             pipe_ready_i,
    output logic             issue_ready_o,
    output logic             issue_accept_o,
    input  logic             commit_valid_i,
    input  logic [ID_W-1:0]  commit_id_i,
    input  logic             commit_kill_i,
    input  logic [NID-1:0]   clear_i,
    output logic [NID-1:0]   issue_o,
    output logic [NID-1:0]   commit_o,
    output logic [NID-1:0]   kill_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] MaxOutC = CNT_W'(MAX_OUT);

    logic [NID-1:0]   issue_q, issue_d;
    logic [NID-1:0]   commit_q, commit_d;
    logic [NID-1:0]   kill_q, kill_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             err_q, err_d;

    logic             issueFire;
    logic             cmtHit;
    logic             multiClr;
    logic [NID-1:0]   issueMask;
    logic [NID-1:0]   cmtMask;
    logic [NID-1:0]   clrEff;
    logic [NID-1:0]   cmtApply;
    logic [CNT_W-1:0] clrCnt;

    assign issue_ready_o  = pipe_ready_i & ~issue_q[issue_id_i] & (outstanding_q < MaxOutC);
    assign issue_accept_o = issue_valid_i & issue_decoded_i;
    assign issueFire      = issue_valid_i & issue_ready_o & issue_decoded_i;

    // Priority on one id: issue beats clear, clear beats commit/kill.
    always_comb begin
        issueMask = '0;
        cmtMask   = '0;
        clrCnt    = '0;
        if (issueFire) begin
            issueMask[issue_id_i] = 1'b1;
        end
        if (commit_valid_i) begin
            cmtMask[commit_id_i] = 1'b1;
        end

        cmtHit   = commit_valid_i &
                   (issue_q[commit_id_i] | (issueFire & (issue_id_i == commit_id_i)));
        multiClr = (clear_i & (clear_i - NID'(1))) != '0;
        clrEff   = clear_i & issue_q & ~issueMask;
        cmtApply = cmtHit ? (cmtMask & ~clrEff) : '0;

        for (int k = 0; k < NID; k++) begin
            clrCnt = clrCnt + CNT_W'(clrEff[k]);
        end

        issue_d       = (issue_q & ~clrEff) | issueMask;
        commit_d      = (commit_q & ~clrEff & ~issueMask) | (commit_kill_i ? '0 : cmtApply);
        kill_d        = (kill_q & ~clrEff & ~issueMask) | (commit_kill_i ? cmtApply : '0);
        outstanding_d = outstanding_q + CNT_W'(issueFire) - clrCnt;
        err_d         = err_q | (commit_valid_i & ~cmtHit) | multiClr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_q       <= '0;
            commit_q      <= '0;
            kill_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            issue_q       <= issue_d;
            commit_q      <= commit_d;
            kill_q        <= kill_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign issue_o       = issue_q;
    assign commit_o      = commit_q;
    assign kill_o        = kill_q;
    assign outstanding_o = outstanding_q;
    assign busy_o        = outstanding_q != '0;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed bench for fir_xifu_ctrl with default parameters (16 ids, 4 outstanding).
// Expected values are hand-computed constants for each step.
module tb_fir_xifu_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic        issue_valid_i;
    logic [3:0]  issue_id_i;
    logic        issue_decoded_i;
    logic        pipe_ready_i;
    logic        issue_ready_o;
    logic        issue_accept_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic [15:0] clear_i;
    logic [15:0] issue_o;
    logic [15:0] commit_o;
    logic [15:0] kill_o;
    logic [2:0]  outstanding_o;
    logic        busy_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    fir_xifu_ctrl #(.ID_W(4), .MAX_OUT(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid_i),
        .issue_id_i     (issue_id_i),
        .issue_decoded_i(issue_decoded_i),
        .pipe_ready_i   (pipe_ready_i),
        .issue_ready_o  (issue_ready_o),
        .issue_accept_o (issue_accept_o),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .clear_i        (clear_i),
        .issue_o        (issue_o),
        .commit_o       (commit_o),
        .kill_o         (kill_o),
        .outstanding_o  (outstanding_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [3:0] iid, input logic dec,
                                 input logic pr, input logic cv, input logic [3:0] cid,
                                 input logic ck, input logic [15:0] clr);
        issue_valid_i   = iv;
        issue_id_i      = iid;
        issue_decoded_i = dec;
        pipe_ready_i    = pr;
        commit_valid_i  = cv;
        commit_id_i     = cid;
        commit_kill_i   = ck;
        clear_i         = clr;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
    endtask

    initial begin
        $display("[TB] start");
        rst_ni = 1'b0;
        idle();
        #2;
        checkOutput("rst_issue", 64'(issue_o), 64'h0);
        checkOutput("rst_commit", 64'(commit_o), 64'h0);
        checkOutput("rst_kill", 64'(kill_o), 64'h0);
        checkOutput("rst_outstanding", 64'(outstanding_o), 64'h0);
        checkOutput("rst_busy", 64'(busy_o), 64'h0);
        checkOutput("rst_err", 64'(err_o), 64'h0);
        nextCycle();
        rst_ni = 1'b1;

        // Issue id 3, then attempt to reissue it.
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        #1;
        checkOutput("id3_ready", 64'(issue_ready_o), 64'h1);
        checkOutput("id3_accept", 64'(issue_accept_o), 64'h1);
        nextCycle();
        checkOutput("id3_issue", 64'(issue_o), 64'h0008);
        checkOutput("id3_outstanding", 64'(outstanding_o), 64'h1);
        checkOutput("id3_busy", 64'(busy_o), 64'h1);
        checkOutput("id3_reissue_ready", 64'(issue_ready_o), 64'h0);
        nextCycle();
        checkOutput("id3_reissue_issue", 64'(issue_o), 64'h0008);
        checkOutput("id3_reissue_outstanding", 64'(outstanding_o), 64'h1);

        // Commit id 3, then retire it.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("id3_commit", 64'(commit_o), 64'h0008);
        checkOutput("id3_commit_err", 64'(err_o), 64'h0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0008);
        nextCycle();
        checkOutput("id3_clear_issue", 64'(issue_o), 64'h0);
        checkOutput("id3_clear_commit", 64'(commit_o), 64'h0);
        checkOutput("id3_clear_outstanding", 64'(outstanding_o), 64'h0);
        checkOutput("id3_clear_busy", 64'(busy_o), 64'h0);

        // Fill to the outstanding limit with ids 0..3.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
            nextCycle();
        end
        checkOutput("full_issue", 64'(issue_o), 64'h000F);
        checkOutput("full_outstanding", 64'(outstanding_o), 64'h4);
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0002);
        #1;
        checkOutput("full_id4_ready", 64'(issue_ready_o), 64'h0);
        nextCycle();
        checkOutput("clr1_issue", 64'(issue_o), 64'h000D);
        checkOutput("clr1_outstanding", 64'(outstanding_o), 64'h3);
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        #1;
        checkOutput("id4_ready", 64'(issue_ready_o), 64'h1);
        nextCycle();
        checkOutput("id4_issue", 64'(issue_o), 64'h001D);
        checkOutput("id4_outstanding", 64'(outstanding_o), 64'h4);

        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0001);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0004);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0008);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0010);
        nextCycle();
        checkOutput("drain_issue", 64'(issue_o), 64'h0);
        checkOutput("drain_outstanding", 64'(outstanding_o), 64'h0);
        checkOutput("drain_err", 64'(err_o), 64'h0);

        // Kill id 2 in the same cycle it is issued.
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 16'h0000);
        nextCycle();
        checkOutput("kill2_issue", 64'(issue_o), 64'h0004);
        checkOutput("kill2_kill", 64'(kill_o), 64'h0004);
        checkOutput("kill2_commit", 64'(commit_o), 64'h0);
        checkOutput("kill2_err", 64'(err_o), 64'h0);
        checkOutput("kill2_outstanding", 64'(outstanding_o), 64'h1);

        // Clear and commit id 2 together: clear wins, no error.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 16'h0004);
        nextCycle();
        checkOutput("clrcmt_issue", 64'(issue_o), 64'h0);
        checkOutput("clrcmt_commit", 64'(commit_o), 64'h0);
        checkOutput("clrcmt_kill", 64'(kill_o), 64'h0);
        checkOutput("clrcmt_err", 64'(err_o), 64'h0);
        checkOutput("clrcmt_outstanding", 64'(outstanding_o), 64'h0);

        // Undecoded handshake leaves the scoreboard alone.
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        #1;
        checkOutput("undec_accept", 64'(issue_accept_o), 64'h0);
        nextCycle();
        checkOutput("undec_issue", 64'(issue_o), 64'h0);
        checkOutput("undec_outstanding", 64'(outstanding_o), 64'h0);

        // Commit of an id that was never issued.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("stray_commit", 64'(commit_o), 64'h0);
        checkOutput("stray_err", 64'(err_o), 64'h1);
        idle();
        nextCycle();
        nextCycle();
        checkOutput("stray_err_sticky", 64'(err_o), 64'h1);

        // Asynchronous reset with three instructions in flight.
        for (int i = 8; i < 11; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
            nextCycle();
        end
        checkOutput("pre_rst_issue", 64'(issue_o), 64'h0700);
        checkOutput("pre_rst_outstanding", 64'(outstanding_o), 64'h3);
        idle();
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_issue", 64'(issue_o), 64'h0);
        checkOutput("arst_outstanding", 64'(outstanding_o), 64'h0);
        checkOutput("arst_busy", 64'(busy_o), 64'h0);
        checkOutput("arst_err", 64'(err_o), 64'h0);
        nextCycle();
        rst_ni = 1'b1;

        // Two clear bits at once: both retire and the error flag rises.
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("post_rst_issue", 64'(issue_o), 64'h0002);
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("pair_issue", 64'(issue_o), 64'h0006);
        checkOutput("pair_outstanding", 64'(outstanding_o), 64'h2);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0006);
        nextCycle();
        checkOutput("multiclr_issue", 64'(issue_o), 64'h0);
        checkOutput("multiclr_outstanding", 64'(outstanding_o), 64'h0);
        checkOutput("multiclr_err", 64'(err_o), 64'h1);

        idle();
        nextCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
